sprite_layer_mapper: RTL and testbench

Parametrised, pipelined pixel colour generator for the VGA path. It holds a table of N_SPRITES glyph sprites, each with position, glyph index, colour and enable, written by the NIOS-side bus. Tables are double-buffered, so updates only become visible at frame start. Each pixel fetches one row of a glyph from the shared font ROM and produces registered VGA_R/G/B with a fixed 2-cycle latency.

---
 rtl/sprite_layer_mapper.sv | 126 ++++++++++++
 tb/tb_sprite_layer_mapper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_mapper.sv
// Purpose: per-pixel sprite compositor with a double-buffered sprite table and shared font ROM lookup.
// Latency: DrawX/DrawY to VGA_R/G/B is exactly 2 clocks; table writes become visible after the next frame_start.
// Backpressure: none, because the pixel stream cannot stall; a write to an out-of-range slot is dropped.
module sprite_layer_mapper #(
    parameter int          N_SPRITES  = 4,
    parameter int          SCALE_LOG2 = 0,
    parameter logic [23:0] BG_COLOR   = 24'h000044,
    localparam int         SLOT_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [6:0]        wr_glyph,
    input  logic [23:0]       wr_color,
    input  logic              wr_enable,
    output logic [10:0]       rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B
);

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [6:0]  glyph;
        logic [23:0] color;
        logic        en;
    } spr_t;

    localparam logic [10:0] SPR_W = 11'(8 << SCALE_LOG2);
    localparam logic [10:0] SPR_H = 11'(16 << SCALE_LOG2);

    spr_t        shadow_q [N_SPRITES];
    spr_t        shadow_d [N_SPRITES];
    spr_t        active_q [N_SPRITES];
    spr_t        active_d [N_SPRITES];
    logic        hit_q,   hit_d;
    logic [2:0]  col_q,   col_d;
    logic [23:0] color_q, color_d;
    logic [23:0] vga_q,   vga_d;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        // Commit copies the pre-edge shadow, so a same-cycle write waits for the next frame.
        if (frame_start) begin
            active_d = shadow_q;
        end
        if (wr_en && (int'(wr_slot) < N_SPRITES)) begin
            shadow_d[wr_slot] = '{x: wr_x, y: wr_y, glyph: wr_glyph, color: wr_color, en: wr_enable};
        end
    end

    logic [10:0] px, py, dx, dy, x_end, y_end;
    logic [6:0]  glyph_sel;
    logic [3:0]  row_sel;

    // Eleven-bit compares keep sprites near column/row 1023 from wrapping to the left/top edge.
    always_comb begin
        hit_d     = 1'b0;
        col_d     = 3'd0;
        color_d   = 24'd0;
        glyph_sel = 7'd0;
        row_sel   = 4'd0;
        px        = {1'b0, DrawX};
        py        = {1'b0, DrawY};
        dx        = 11'd0;
        dy        = 11'd0;
        x_end     = 11'd0;
        y_end     = 11'd0;
        for (int i = 0; i < N_SPRITES; i++) begin
            x_end = {1'b0, active_q[i].x} + SPR_W;
            y_end = {1'b0, active_q[i].y} + SPR_H;
            dx    = px - {1'b0, active_q[i].x};
            dy    = py - {1'b0, active_q[i].y};
            if (!hit_d && active_q[i].en
                && (px >= {1'b0, active_q[i].x}) && (px < x_end)
                && (py >= {1'b0, active_q[i].y}) && (py < y_end)) begin
                hit_d     = 1'b1;
                col_d     = 3'(dx >> SCALE_LOG2);
                row_sel   = 4'(dy >> SCALE_LOG2);
                color_d   = active_q[i].color;
                glyph_sel = active_q[i].glyph;
            end
        end
        rom_addr = {glyph_sel, row_sel};
    end

    // The winner alone decides the pixel: a transparent bit shows background, never a lower slot.
    always_comb begin
        vga_d = BG_COLOR;
        if (hit_q && rom_data[3'd7 - col_q]) begin
            vga_d = color_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            hit_q   <= 1'b0;
            col_q   <= 3'd0;
            color_q <= 24'd0;
            vga_q   <= 24'd0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            hit_q    <= hit_d;
            col_q    <= col_d;
            color_q  <= color_d;
            vga_q    <= vga_d;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = vga_q;

endmodule

// File: tb/tb_sprite_layer_mapper.sv
// Bench for sprite_layer_mapper: two instances (4 slots unscaled, 3 slots at 2x) share stimulus;
// a table-level model predicts every output cycle, and directed literals pin the model.
module tb_sprite_layer_mapper;

    localparam logic [23:0] BG = 24'h000044;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        frame_start, wr_en, wr_enable;
    logic [1:0]  wr_slot;
    logic [9:0]  wr_x, wr_y;
    logic [6:0]  wr_glyph;
    logic [23:0] wr_color;
    logic [10:0] rom_addr0, rom_addr1;
    logic [7:0]  rom_data0, rom_data1;
    logic [7:0]  r0, g0, b0, r1, g1, b1;

    always #5 Clk = ~Clk;

    sprite_layer_mapper #(.N_SPRITES(4), .SCALE_LOG2(0), .BG_COLOR(BG)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_x(wr_x), .wr_y(wr_y), .wr_glyph(wr_glyph),
        .wr_color(wr_color), .wr_enable(wr_enable), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .VGA_R(r0), .VGA_G(g0), .VGA_B(b0));

    sprite_layer_mapper #(.N_SPRITES(3), .SCALE_LOG2(1), .BG_COLOR(BG)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_x(wr_x), .wr_y(wr_y), .wr_glyph(wr_glyph),
        .wr_color(wr_color), .wr_enable(wr_enable), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1));

    logic [7:0] rom_mem [0:2047];
    always @(posedge Clk) begin
        rom_data0 <= rom_mem[rom_addr0];
        rom_data1 <= rom_mem[rom_addr1];
    end

    typedef struct {int x; int y; int g; int c; bit en;} spr_m;
    spr_m        sh [2][4];
    spr_m        ac [2][4];
    int          nsp [2] = '{4, 3};
    int          scl [2] = '{0, 1};
    logic [23:0] stage_m [2];
    logic [23:0] out_m [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    function automatic int find(int d, int px, int py);
        for (int i = 0; i < nsp[d]; i++) begin
            if (ac[d][i].en && px >= ac[d][i].x && px < ac[d][i].x + (8 << scl[d])
                && py >= ac[d][i].y && py < ac[d][i].y + (16 << scl[d]))
                return i;
        end
        return -1;
    endfunction

    function automatic int addr_of(int d, int px, int py);
        int s;
        s = find(d, px, py);
        if (s < 0) return 0;
        return ac[d][s].g * 16 + (py - ac[d][s].y) / (1 << scl[d]);
    endfunction

    function automatic logic [23:0] pix_of(int d, int px, int py);
        int s;
        int col;
        logic [7:0] bits;
        s = find(d, px, py);
        if (s < 0) return BG;
        col  = (px - ac[d][s].x) / (1 << scl[d]);
        bits = rom_mem[addr_of(d, px, py)];
        return bits[7 - col] ? 24'(ac[d][s].c) : BG;
    endfunction

    // Model: pixel predicted at the sampling edge appears on VGA one edge later.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) begin
                    sh[d][i] = '{0, 0, 0, 0, 1'b0};
                    ac[d][i] = '{0, 0, 0, 0, 1'b0};
                end
                stage_m[d] = BG;
                out_m[d]   = 24'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                out_m[d]   = stage_m[d];
                stage_m[d] = pix_of(d, int'(DrawX), int'(DrawY));
                if (frame_start)
                    for (int i = 0; i < 4; i++) ac[d][i] = sh[d][i];
                if (wr_en && int'(wr_slot) < nsp[d])
                    sh[d][wr_slot] = '{int'(wr_x), int'(wr_y), int'(wr_glyph), int'(wr_color), wr_enable};
            end
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("vga0", {8'd0, r0, g0, b0}, {8'd0, out_m[0]});
            check("vga1", {8'd0, r1, g1, b1}, {8'd0, out_m[1]});
            check("rom_addr0", {21'd0, rom_addr0}, 32'(addr_of(0, int'(DrawX), int'(DrawY))));
            check("rom_addr1", {21'd0, rom_addr1}, 32'(addr_of(1, int'(DrawX), int'(DrawY))));
        end
    end

    task automatic pix(int x, int y);
        @(posedge Clk); #1;
        DrawX = 10'(x);
        DrawY = 10'(y);
    endtask

    task automatic wr(int s, int x, int y, int g, int c, bit fs);
        @(posedge Clk); #1;
        wr_en = 1'b1; wr_slot = 2'(s); wr_x = 10'(x); wr_y = 10'(y);
        wr_glyph = 7'(g); wr_color = 24'(c); wr_enable = 1'b1; frame_start = fs;
        @(posedge Clk); #1;
        wr_en = 1'b0; frame_start = 1'b0;
    endtask

    task automatic fs_pulse();
        @(posedge Clk); #1 frame_start = 1'b1;
        @(posedge Clk); #1 frame_start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge Clk);
        #2;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) rom_mem[a] = 8'(a * 29 + 7);
        rom_mem[11'h483] = 8'b1000_0000;
        rom_mem[11'h493] = 8'hFF;
        rom_mem[11'h418] = 8'b0100_0000;
        Reset_n = 1'b0; DrawX = '0; DrawY = '0; frame_start = 1'b0; wr_en = 1'b0;
        wr_slot = '0; wr_x = '0; wr_y = '0; wr_glyph = '0; wr_color = '0; wr_enable = 1'b0;
        @(posedge Clk); #1 chk_en = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Empty table: background across a full line.
        for (int x = 0; x < 640; x++) pix(x, 0);
        settle();
        check("sweep_bg", {8'd0, r0, g0, b0}, 32'h000044);
        check("sweep_addr", {21'd0, rom_addr0}, 32'd0);

        wr(0, 300, 300, 7'h48, 24'h00FFFF, 1'b0);
        fs_pulse();
        pix(300, 303); settle();
        check("s0_addr", {21'd0, rom_addr0}, 32'h483);
        check("s0_rom", {24'd0, rom_data0}, 32'h80);
        check("s0_on", {8'd0, r0, g0, b0}, 32'h00FFFF);
        pix(301, 303); settle();
        check("s0_off", {8'd0, r0, g0, b0}, 32'h000044);

        // Slot 1 on top of slot 0: hidden until commit, then still loses priority.
        wr(1, 300, 300, 7'h49, 24'hFFFF00, 1'b0);
        pix(300, 303); settle();
        check("shadow_hidden", {8'd0, r0, g0, b0}, 32'h00FFFF);
        fs_pulse(); settle();
        check("prio", {8'd0, r0, g0, b0}, 32'h00FFFF);
        pix(301, 303); settle();
        check("no_fallthru", {8'd0, r0, g0, b0}, 32'h000044);

        wr(0, 300, 300, 7'h48, 24'hFF0000, 1'b1);
        pix(300, 303); settle();
        check("same_cycle_old", {8'd0, r0, g0, b0}, 32'h00FFFF);
        fs_pulse(); settle();
        check("same_cycle_new", {8'd0, r0, g0, b0}, 32'hFF0000);

        wr(2, 100, 100, 7'h41, 24'h123456, 1'b0);
        fs_pulse();
        pix(103, 117); settle();
        check("scale_addr", {21'd0, rom_addr1}, 32'h418);
        check("scale_on", {8'd0, r1, g1, b1}, 32'h123456);
        pix(116, 117); settle();
        check("scale_edge_addr", {21'd0, rom_addr1}, 32'd0);
        check("scale_edge_bg", {8'd0, r1, g1, b1}, 32'h000044);

        // Slot 3 exists only in the 4-slot instance.
        wr(3, 500, 500, 7'h22, 24'hABCDEF, 1'b0);
        fs_pulse();
        pix(501, 501); settle();
        check("slot3_addr0", {21'd0, rom_addr0}, 32'h221);
        check("slot3_ignored", {21'd0, rom_addr1}, 32'd0);

        wr(0, 1020, 10, 7'h30, 24'h00FF00, 1'b0);
        fs_pulse();
        pix(2, 12); settle();
        check("nowrap_addr", {21'd0, rom_addr0}, 32'd0);
        check("nowrap_bg", {8'd0, r0, g0, b0}, 32'h000044);
        pix(1022, 12); settle();
        check("edge_addr", {21'd0, rom_addr0}, 32'h302);

        @(posedge Clk); #3 Reset_n = 1'b0;
        #1;
        check("rst_vga0", {8'd0, r0, g0, b0}, 32'd0);
        check("rst_vga1", {8'd0, r1, g1, b1}, 32'd0);
        check("rst_addr", {21'd0, rom_addr0}, 32'd0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk); #2;
        check("post_rst_bg", {8'd0, r0, g0, b0}, 32'h000044);
        settle();
        check("post_rst_addr", {21'd0, rom_addr0}, 32'd0);
        fs_pulse(); settle();
        check("post_rst_commit", {21'd0, rom_addr0}, 32'd0);
        check("post_rst_vga", {8'd0, r0, g0, b0}, 32'h000044);

        @(posedge Clk); #1 chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
